// File: rtl/uart_pkg.sv
// Shared UART definitions used by the buffered transmitter and the receiver.
// Defining UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per bit, truncated.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO: rd_data shows the head entry whenever empty is low.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_wr, do_rd;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (do_wr && !do_rd)      level_d = level_q + (AW+1)'(1);
        else if (!do_wr && do_rd) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, LSB first, registered tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_SPEED = 27000000,
    parameter int BAUD_RATE = 115200,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int DIV   = baud_div(CLK_SPEED, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    tx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif
    logic                      pop, push, full, empty, baud_end;
    logic [UART_DATA_BITS-1:0] fifo_data;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign tx       = tx_q;
    assign busy     = (state_q != TX_IDLE) || (level != '0);
    assign baud_end = (baud_q == BAUD_LAST);

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // tx_d carries the line level of the state being entered, so tx stays glitch-free.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = TX_START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_data;
`endif
                end
            end
            TX_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        state_d = TX_START;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_data;
`endif
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them on the `tx` line as 8N1 frames (8E1 when parity is enabled), LSB first. It is the transmit-side counterpart to the UART receiver in the loopback/echo top. The receiver's byte stream can feed it directly, and bursts arrive faster than the line drains, so the FIFO absorbs them.

## Interface
Parameters:
- `CLK_SPEED`, 27000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DEPTH`, 16: FIFO depth in bytes; must be a power of two and ≥2.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_data`, input, 8: byte to transmit.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: FIFO can accept a byte.
- `tx`, output, 1: serial line, idle high; registered.
- `busy`, output, 1: a frame is in progress or the FIFO is non-empty.
- `level`, output, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Bit period `DIV = CLK_SPEED / BAUD_RATE`, integer division, truncated. With the defaults, DIV = 234.
- Push: a byte is accepted on any rising edge with `in_valid && in_ready`. `in_ready = !full`, and it is 0 while `rst` is high.
- The FIFO is full at `level == DEPTH`. With a push attempt while full, `in_ready` is 0, so the byte is not taken and no overwrite occurs.
- Push and pop in the same cycle: `level` stays unchanged and both operations take effect. This applies at any non-full level.
- FSM states:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for DIV cycles, then go to DATA.
  - DATA: send bits 0..7, each held for DIV cycles. After bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: see Configuration.
  - STOP: `tx` = 1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Bit counter is 3 bits and wraps after bit 7.
- Baud counter counts 0..DIV-1 and reloads on every state change.
- `busy = (state != IDLE) || (level != 0)`.
- Reset, including mid-frame: the frame is abandoned, the FIFO is cleared, the FSM returns to IDLE, and `tx` = 1 on the cycle after the reset edge. There is no glitch low.
- Reset values: `tx`=1, `busy`=0, `level`=0, `in_ready`=0 during reset and 1 on the first cycle after reset.

## Timing
- Push accepted at edge E0 with the FSM idle and FIFO empty:
  - After E0: `level` = 1.
  - At E1: pop, `level` = 0, and `tx` drives 0 from E1.
  - First-byte latency is 1 cycle from acceptance to the start bit.
- Frame length is 10×DIV cycles (2340 at defaults), or 11×DIV with parity.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the same edge the FSM enters IDLE with an empty FIFO.
- Sustained throughput is one byte per frame length. The handshake never stalls while `level < DEPTH`.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in. After bit 7, the FSM sends the even-parity bit (XOR of the 8 data bits) for DIV cycles. Frame is 11 bit times.
- Undefined: the PARITY state and its logic are absent. DATA goes directly to STOP. Frame is 10 bit times.

## Structure
- Package `uart_pkg`:
  - FSM state enum `tx_state_t`.
  - Function `baud_div(clk, baud)`.
  - Constant `UART_DATA_BITS = 8`.
  - The receiver imports the same package.
- Sub-module `uart_byte_fifo`: synchronous FIFO, parameter DEPTH.
  - Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `level`.
  - Read data is valid in the same cycle as `!empty` (first-word fall-through).
- Top of this block: FSM, baud counter, shift register, parity.

## Test plan
- Single byte 0x55 at defaults:
  - `tx` low 1 cycle after acceptance.
  - Line pattern 0,1,0,1,0,1,0,1,0,1 (start, bits 0..7, stop), each bit 234 cycles.
  - `busy` drops after 2340+1 cycles.
- Burst of 20 bytes 0x00..0x13 with `in_valid` held high, DEPTH=16:
  - `in_ready` drops when `level` = 16.
  - All 20 bytes are transmitted in order with zero idle gaps between frames.
- Push while full with `in_valid` held:
  - Byte 0xA5 is accepted only on the cycle after the first stop bit completes (`level` 16→15→16).
  - No data loss or duplication.
- Reset asserted mid-DATA of 0xF0, 3 more bytes queued:
  - `tx` = 1 the next cycle, `level` = 0, `busy` = 0.
  - The next pushed byte 0x3C transmits cleanly.
- With `UART_TX_PARITY_EN`:
  - Byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0.
  - Frame is 2574 cycles.
- Loopback with the UART receiver at 27 MHz/115200:
  - 256 bytes 0x00..0xFF are received identically.
